// File: rtl/mem_stage_pkg.sv
// mem_stage shared definitions: bus widths, stall levels, load flags,
// FSM encodings and bus layouts. Optional feature macro: MEM_ADDR_EXC_EN.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 76;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 38;
  localparam int STALL_WD     = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int MEM_STALL = 3;
  localparam int WB_STALL  = 4;

  // load flag bit order {lb, lbu, lh, lhu, lw}
  localparam int LB  = 4;
  localparam int LBU = 3;
  localparam int LH  = 2;
  localparam int LHU = 1;
  localparam int LW  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_wb_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_id_t;

  // Word loads need a 4-byte aligned address, half loads a 2-byte one.
  // All-zero flags on a load behave as lw.
  function automatic logic misaligned(
    input logic [4:0] flags,
    input logic [1:0] addr
  );
    logic lw_eff;
    lw_eff = flags[LW] | (flags == 5'd0);
    return (lw_eff & (|addr)) |
           ((flags[LH] | flags[LHU]) & addr[0]);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage interface: EX->MEM inputs, SRAM read return, WB/ID buses.
// MEM_ADDR_EXC_EN adds the mem_addr_exc flag.
interface mem_stage_if
  import mem_stage_pkg::*;
();

  logic [STALL_WD-1:0]     stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [4:0]              load_sram_ex_data;
  logic [3:0]              data_ram_sel;
  logic [31:0]             data_sram_rdata;
  logic                    data_sram_rvalid;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;
  logic                    stallreq_for_mem;
`ifdef MEM_ADDR_EXC_EN
  logic                    mem_addr_exc;
`endif

  modport master (
    output stall,
    output ex_to_mem_bus,
    output load_sram_ex_data,
    output data_ram_sel,
    output data_sram_rdata,
    output data_sram_rvalid,
`ifdef MEM_ADDR_EXC_EN
    input  mem_addr_exc,
`endif
    input  mem_to_wb_bus,
    input  mem_to_id_bus,
    input  stallreq_for_mem
  );

  modport slave (
    input  stall,
    input  ex_to_mem_bus,
    input  load_sram_ex_data,
    input  data_ram_sel,
    input  data_sram_rdata,
    input  data_sram_rvalid,
`ifdef MEM_ADDR_EXC_EN
    output mem_addr_exc,
`endif
    output mem_to_wb_bus,
    output mem_to_id_bus,
    output stallreq_for_mem
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load data lane select and sign/zero extension.
// Pure combinational; all-zero flags pass the word through.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [3:0]  sel,
  input  logic [4:0]  flags,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // pick the byte and half lanes from the byte-select
  always_comb begin
    byte_v = 8'h00;
    half_v = 16'h0000;
    unique case (sel)
      4'b0001: byte_v = raw[7:0];
      4'b0010: byte_v = raw[15:8];
      4'b0100: byte_v = raw[23:16];
      4'b1000: byte_v = raw[31:24];
      default: byte_v = 8'h00;
    endcase
    unique case (sel)
      4'b0011: half_v = raw[15:0];
      4'b1100: half_v = raw[31:16];
      default: half_v = 16'h0000;
    endcase
  end

  // extend according to the load type
  always_comb begin
    data = raw;
    unique case (1'b1)
      flags[LB]:  data = {{24{byte_v[7]}}, byte_v};
      flags[LBU]: data = {24'h0, byte_v};
      flags[LH]:  data = {{16{half_v[15]}}, half_v};
      flags[LHU]: data = {16'h0, half_v};
      default:    data = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX->MEM register, SRAM wait FSM, load alignment.
// MEM_ADDR_EXC_EN enables misaligned-load detection (mem_addr_exc).
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);

  ex_mem_t     ex_r;
  logic [4:0]  flags_r;
  logic [3:0]  sel_r;
  state_t      state;
  state_t      state_n;
  logic [31:0] data_buf;
  logic        cap;
  logic        stallreq;
  logic        is_load;
  logic        bad_addr;
  logic        load_go;
  logic        rvalid;
  logic        mem_stop;
  logic        wb_stop;
  logic [31:0] raw;
  logic [31:0] ld_data;
  logic [31:0] wdata;
  logic        we;
  mem_wb_t     wb;
  mem_id_t     fwd;
  logic        unused;

  assign rvalid   = bus.data_sram_rvalid;
  assign mem_stop = bus.stall[MEM_STALL] == STOP;
  assign wb_stop  = bus.stall[WB_STALL] == STOP;

  // pipeline register: bubble when MEM stalls and WB runs
  always_ff @(posedge clk) begin
    if (rst || (mem_stop && !wb_stop)) begin
      ex_r    <= '0;
      flags_r <= '0;
      sel_r   <= '0;
    end else if (!mem_stop) begin
      ex_r    <= bus.ex_to_mem_bus;
      flags_r <= bus.load_sram_ex_data;
      sel_r   <= bus.data_ram_sel;
    end
  end

  assign is_load = ex_r.sel_rf_res & ex_r.ram_en;

`ifdef MEM_ADDR_EXC_EN
  assign bad_addr = is_load &
    misaligned(flags_r, ex_r.ex_result[1:0]);
  assign bus.mem_addr_exc = bad_addr;
`else
  assign bad_addr = 1'b0;
`endif

  assign load_go = is_load & ~bad_addr;

  // wait FSM state and captured read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_buf <= '0;
    end else begin
      state <= state_n;
      if (cap) data_buf <= bus.data_sram_rdata;
    end
  end

  // next state, capture and stall request
  always_comb begin
    state_n  = state;
    cap      = 1'b0;
    stallreq = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_go) begin
          if (!rvalid) begin
            state_n  = WAIT;
            stallreq = 1'b1;
          end else if (mem_stop) begin
            state_n = HELD;
            cap     = 1'b1;
          end
        end
      end
      WAIT: begin
        if (rvalid) begin
          if (mem_stop) begin
            state_n = HELD;
            cap     = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          stallreq = 1'b1;
        end
      end
      HELD: begin
        if (!mem_stop) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign raw = (state == HELD) ? data_buf : bus.data_sram_rdata;

  mem_stage_load_align u_align (
    .raw   (raw),
    .sel   (sel_r),
    .flags (flags_r),
    .data  (ld_data)
  );

  assign wdata = is_load ? ld_data : ex_r.ex_result;
  assign we    = ex_r.rf_we & ~bad_addr;

  assign wb.pc       = ex_r.pc;
  assign wb.rf_we    = we;
  assign wb.rf_waddr = ex_r.rf_waddr;
  assign wb.rf_wdata = wdata;

  assign fwd.rf_we    = we & ~stallreq;
  assign fwd.rf_waddr = ex_r.rf_waddr;
  assign fwd.rf_wdata = wdata;

  assign bus.mem_to_wb_bus    = wb;
  assign bus.mem_to_id_bus    = fwd;
  assign bus.stallreq_for_mem = stallreq;

  assign unused = ^{ex_r.ram_wen, bus.stall[5], bus.stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle loads plus
// wait, hold, reset, bubble and (with MEM_ADDR_EXC_EN) alignment cases.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam logic [31:0] PC = 32'h0040_0010;
  localparam logic [4:0] F_LB  = 5'b10000;
  localparam logic [4:0] F_LBU = 5'b01000;
  localparam logic [4:0] F_LH  = 5'b00100;
  localparam logic [4:0] F_LHU = 5'b00010;
  localparam logic [4:0] F_LW  = 5'b00001;
  localparam logic [4:0] F_NO  = 5'b00000;

  logic clk = 1'b0;
  logic rst;

  mem_stage_if bus();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        ld;
    logic [4:0]  fl;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm,
                     input logic [69:0] act,
                     input logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic ld, input logic [4:0] fl,
                     input logic [3:0] sel, input logic [31:0] addr);
    bus.ex_to_mem_bus     = {PC, ld, 4'h0, ld, 1'b1, 5'd7, addr};
    bus.load_sram_ex_data = fl;
    bus.data_ram_sel      = sel;
  endtask

  function automatic logic [69:0] wbx(input logic [31:0] d,
                                      input logic we);
    return {PC, we, 5'd7, d};
  endfunction

  function automatic logic [37:0] idx(input logic [31:0] d,
                                      input logic we);
    return {we, 5'd7, d};
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, F_LW,  4'b1111, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[1] = '{1'b1, F_LB,  4'b0100, 32'h102, 32'h00800000, 32'hFFFFFF80};
    vt[2] = '{1'b1, F_LBU, 4'b0100, 32'h102, 32'h00800000, 32'h00000080};
    vt[3] = '{1'b1, F_LH,  4'b1100, 32'h102, 32'h80010000, 32'hFFFF8001};
    vt[4] = '{1'b1, F_LHU, 4'b0011, 32'h100, 32'h1234F00D, 32'h0000F00D};
    vt[5] = '{1'b1, F_LB,  4'b0001, 32'h100, 32'h0000007F, 32'h0000007F};
    vt[6] = '{1'b1, F_LH,  4'b0011, 32'h100, 32'h00008000, 32'hFFFF8000};
    vt[7] = '{1'b1, F_NO,  4'b1111, 32'h104, 32'h01234567, 32'h01234567};
    vt[8] = '{1'b1, F_LBU, 4'b1000, 32'h103, 32'hAB000000, 32'h000000AB};
    vt[9] = '{1'b0, F_NO,  4'b0000, 32'hCAFEF00D, 32'h5A5A5A5A,
              32'hCAFEF00D};

    rst = 1'b1;
    bus.stall = '0;
    bus.ex_to_mem_bus = '0;
    bus.load_sram_ex_data = '0;
    bus.data_ram_sel = '0;
    bus.data_sram_rdata = '0;
    bus.data_sram_rvalid = 1'b0;
    step();
    step();
    chk("rst_wb", bus.mem_to_wb_bus, '0);
    chk("rst_id", bus.mem_to_id_bus, '0);
    chk("rst_stallreq", bus.stallreq_for_mem, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      put(vt[i].ld, vt[i].fl, vt[i].sel, vt[i].addr);
      bus.stall = '0;
      bus.data_sram_rvalid = 1'b0;
      step();
      bus.data_sram_rvalid = 1'b1;
      bus.data_sram_rdata = vt[i].rdata;
      #1;
      chk($sformatf("vec%0d_wb", i), bus.mem_to_wb_bus,
          wbx(vt[i].exp, 1'b1));
      chk($sformatf("vec%0d_id", i), bus.mem_to_id_bus,
          idx(vt[i].exp, 1'b1));
      chk($sformatf("vec%0d_stallreq", i), bus.stallreq_for_mem, 1'b0);
    end

    // read data three cycles late
    bus.data_sram_rvalid = 1'b0;
    put(1'b1, F_LW, 4'b1111, 32'h200);
    step();
    for (int i = 0; i < 3; i++) begin
      bus.stall = 6'h3f;
      #1;
      chk($sformatf("wait%0d_stallreq", i), bus.stallreq_for_mem, 1'b1);
      chk($sformatf("wait%0d_id_we", i), bus.mem_to_id_bus[37], 1'b0);
      step();
    end
    bus.stall = '0;
    bus.data_sram_rvalid = 1'b1;
    bus.data_sram_rdata = 32'h0BADF00D;
    put(1'b0, F_NO, 4'b0000, 32'h77);
    #1;
    chk("late_stallreq", bus.stallreq_for_mem, 1'b0);
    chk("late_wb", bus.mem_to_wb_bus, wbx(32'h0BADF00D, 1'b1));
    chk("late_id", bus.mem_to_id_bus, idx(32'h0BADF00D, 1'b1));
    step();
    bus.data_sram_rvalid = 1'b0;
    #1;
    chk("after_late_wb", bus.mem_to_wb_bus, wbx(32'h77, 1'b1));

    // data arrives while MEM is stopped: captured and held
    put(1'b1, F_LW, 4'b1111, 32'h300);
    step();
    bus.stall = 6'h3f;
    bus.data_sram_rvalid = 1'b1;
    bus.data_sram_rdata = 32'h11223344;
    #1;
    chk("held_first_wb", bus.mem_to_wb_bus, wbx(32'h11223344, 1'b1));
    chk("held_first_stallreq", bus.stallreq_for_mem, 1'b0);
    step();
    bus.data_sram_rvalid = 1'b0;
    bus.data_sram_rdata = 32'h0;
    #1;
    chk("held_keep_wb", bus.mem_to_wb_bus, wbx(32'h11223344, 1'b1));
    chk("held_keep_id", bus.mem_to_id_bus, idx(32'h11223344, 1'b1));
    step();
    chk("held_keep2_wb", bus.mem_to_wb_bus, wbx(32'h11223344, 1'b1));
    bus.stall = '0;
    put(1'b0, F_NO, 4'b0000, 32'h55);
    #1;
    chk("held_rel_wb", bus.mem_to_wb_bus, wbx(32'h11223344, 1'b1));
    step();
    chk("post_held_wb", bus.mem_to_wb_bus, wbx(32'h55, 1'b1));

    // reset while waiting, then a stray rvalid
    put(1'b1, F_LW, 4'b1111, 32'h400);
    step();
    chk("idle_again_stallreq", bus.stallreq_for_mem, 1'b1);
    bus.stall = 6'h3f;
    step();
    chk("wait_pre_rst", bus.stallreq_for_mem, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.stall = '0;
    bus.ex_to_mem_bus = '0;
    bus.load_sram_ex_data = '0;
    bus.data_ram_sel = '0;
    #1;
    chk("mid_rst_stallreq", bus.stallreq_for_mem, 1'b0);
    chk("mid_rst_wb", bus.mem_to_wb_bus, '0);
    chk("mid_rst_id", bus.mem_to_id_bus, '0);
    bus.data_sram_rvalid = 1'b1;
    bus.data_sram_rdata = 32'hFFFFFFFF;
    #1;
    chk("stray_wb", bus.mem_to_wb_bus, '0);
    chk("stray_stallreq", bus.stallreq_for_mem, 1'b0);
    step();
    bus.data_sram_rvalid = 1'b0;
    #1;
    chk("stray_after_wb", bus.mem_to_wb_bus, '0);
    chk("stray_after_id", bus.mem_to_id_bus, '0);

    // MEM stop with WB running inserts a bubble
    put(1'b0, F_NO, 4'b0000, 32'h99);
    step();
    chk("pre_bubble_wb", bus.mem_to_wb_bus, wbx(32'h99, 1'b1));
    bus.stall = 6'b001000;
    step();
    chk("bubble_wb", bus.mem_to_wb_bus, '0);
    chk("bubble_id", bus.mem_to_id_bus, '0);
    bus.stall = '0;

`ifdef MEM_ADDR_EXC_EN
    put(1'b1, F_LW, 4'b1111, 32'h102);
    bus.data_sram_rvalid = 1'b0;
    step();
    chk("exc_lw_flag", bus.mem_addr_exc, 1'b1);
    chk("exc_lw_wb_we", bus.mem_to_wb_bus[37], 1'b0);
    chk("exc_lw_id_we", bus.mem_to_id_bus[37], 1'b0);
    chk("exc_lw_stallreq", bus.stallreq_for_mem, 1'b0);
    put(1'b1, F_LH, 4'b1100, 32'h102);
    step();
    bus.data_sram_rvalid = 1'b1;
    bus.data_sram_rdata = 32'h80010000;
    #1;
    chk("exc_lh_flag", bus.mem_addr_exc, 1'b0);
    chk("exc_lh_wb", bus.mem_to_wb_bus, wbx(32'hFFFF8001, 1'b1));
    bus.data_sram_rvalid = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
